// File: rtl/i2s_transmitter_if.sv
// Sample/control handshake and I2S pin bundle between upstream buffer, transmitter and DAC.
interface i2s_transmitter_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic                    enable;
  logic [SAMPLE_WIDTH-1:0] data;
  logic                    ready;
  logic                    i2s_bclk;
  logic                    i2s_lrclk;
  logic                    i2s_sdata;
  logic                    busy;

  modport master (
    input  enable,
    input  data,
    output ready,
    output i2s_bclk,
    output i2s_lrclk,
    output i2s_sdata,
    output busy
  );

  modport slave (
    output enable,
    output data,
    input  ready,
    input  i2s_bclk,
    input  i2s_lrclk,
    input  i2s_sdata,
    input  busy
  );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S transmitter: divides clk into BCLK/LRCLK and shifts 16-bit samples out MSB first
// with the standard one-BCLK delay, requesting each next sample with a ready pulse.
module i2s_transmitter #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  i2s_transmitter_if.master bus
);
  localparam int unsigned FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_LEFT  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(SAMPLE_WIDTH + 1);
  localparam logic [POS_W-1:0] POS_HALF  = POS_W'(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic                    div_tick;
  logic                    fall;
  logic [POS_W-1:0]        pos_inc;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      pos_q   <= POS_LAST;
      shift_q <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      shift_q <= shift_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: divider, frame position, slot load / shift, drain exit
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    pos_d    = pos_q;
    shift_d  = shift_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;

    div_tick = (div_q == DIV_LAST);
    fall     = div_tick && bclk_q;
    pos_inc  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = RUN;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        state_d = bus.enable ? RUN : DRAIN;
        div_d   = div_tick ? '0 : div_q + DIV_W'(1);
        if (div_tick) begin
          bclk_d = ~bclk_q;
        end
        if (fall) begin
          // Drain ends once the right LSB (pos 0) has been on the wire
          if ((state_q == DRAIN) && !bus.enable && (pos_inc == POS_LEFT)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            pos_d   = POS_LAST;
            shift_d = '0;
          end else begin
            pos_d   = pos_inc;
            lrclk_d = (pos_inc >= POS_HALF);
            if ((pos_inc == POS_LEFT) || (pos_inc == POS_RIGHT)) begin
              shift_d = bus.data;
              sdata_d = bus.data[SAMPLE_WIDTH-1];
              ready_d = 1'b1;
            end else begin
              shift_d = shift_q << 1;
              sdata_d = shift_q[SAMPLE_WIDTH-2];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.i2s_bclk  = bclk_q;
  assign bus.i2s_lrclk = lrclk_q;
  assign bus.i2s_sdata = sdata_q;
  assign bus.busy      = busy_q;

endmodule
